// File: rtl/ctf_pkg.sv
// Shared types and defaults for the counterflow pulse receiver.
package ctf_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } ctf_state_e;

  localparam int CTF_WIDTH   = 8;
  localparam int CTF_TIMEOUT = 255;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int ctf_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctf_pulse_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
module ctf_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic e
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      e      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a};
      prev_q <= sync_q[SYNC_STAGES-1];
      e      <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/ctf_pulse_rx.sv
// Receives dout/cout pulses from the last counterflow cell and assembles
// them LSB-first into WIDTH-bit words with a valid/ready output handshake.
module ctf_pulse_rx
  import ctf_pkg::*;
#(
  parameter int WIDTH       = CTF_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = CTF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dout,
  input  logic             cout,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  output logic             viol_o,
  output logic             timeout_o
);

  localparam int CW = ctf_cw(WIDTH);
  localparam int IW = ctf_cw(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [IW-1:0] TMAX     = IW'(TIMEOUT);
  localparam bit            ONE_SLOT = (WIDTH == 1);

  logic dout_e, cout_e;

  ctf_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dsync (
    .clk(clk), .rst_n(rst_n), .a(dout), .e(dout_e)
  );

  ctf_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csync (
    .clk(clk), .rst_n(rst_n), .a(cout), .e(cout_e)
  );

  ctf_state_e       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [IW-1:0]    idle_q, idle_nx;
  logic             slot_q;
  logic [WIDTH-1:0] acc_q, word_nx;
  logic             bit_val, complete, tmo, load, ovr;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    tmo      = 1'b0;
    bit_val  = slot_q | dout_e;
    idle_nx  = (idle_q == TMAX) ? idle_q : idle_q + 1'b1;
    word_nx  = acc_q;
    word_nx[bit_cnt_q] = bit_val;
    case (state_q)
      IDLE: begin
        if (cout_e) begin
          if (ONE_SLOT) complete = 1'b1;
          else          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cout_e) begin
          if (bit_cnt_q == LAST) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end else if (idle_nx == TMAX) begin
          // Stalled partial word: drop it rather than merge with later traffic.
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load = complete && (!valid_o || ready_i);
    ovr  = complete && valid_o && !ready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      idle_q    <= '0;
      slot_q    <= 1'b0;
      acc_q     <= '0;
      word_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      viol_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      overrun_o <= ovr;
      viol_o    <= dout_e & slot_q;
      timeout_o <= tmo;

      if (cout_e || tmo) slot_q <= 1'b0;
      else if (dout_e)   slot_q <= 1'b1;

      if (complete || tmo) begin
        bit_cnt_q <= '0;
        acc_q     <= '0;
      end else if (cout_e) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        acc_q     <= word_nx;
      end

      if (state_q == COLLECT && !cout_e && !tmo) idle_q <= idle_nx;
      else                                       idle_q <= '0;

      if (load) begin
        word_o  <= word_nx;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctf_pulse_rx.sv
// Randomized self-checking bench for ctf_pulse_rx (WIDTH=8).
module tb_ctf_pulse_rx;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst_n, dout, cout, ready_i;
  logic [W-1:0] word_o;
  logic         valid_o, overrun_o, viol_o, timeout_o;

  ctf_pulse_rx #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dout(dout), .cout(cout),
    .word_o(word_o), .valid_o(valid_o), .ready_i(ready_i),
    .overrun_o(overrun_o), .viol_o(viol_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation of consumer-side traffic and pulse outputs.
  logic [W-1:0] acc_w [0:1023];
  int acc_n = 0, ov_n = 0, vi_n = 0, to_n = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        acc_w[acc_n] = word_o;
        acc_n++;
      end
      if (overrun_o) ov_n++;
      if (viol_o)    vi_n++;
      if (timeout_o) to_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_dout();
    dout = 1'b1; tick(3);
    dout = 1'b0; tick(3);
  endtask

  task automatic pulse_cout();
    cout = 1'b1; tick(3);
    cout = 1'b0; tick(3);
  endtask

  task automatic send_slot(input int ndout);
    repeat (ndout) pulse_dout();
    pulse_cout();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_slot(w[i] ? 1 : 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dout = 1'b0; cout = 1'b0; ready_i = 1'b0;
    #13;
    checks++;
    if ({word_o, valid_o, overrun_o, viol_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {word_o, valid_o, overrun_o, viol_o, timeout_o});
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_valid got=%b want=0", valid_o);
    end
  endtask

  // 8'h4D with exact output latency measured from the last raw cout edge.
  task automatic test_latency();
    logic [W-1:0] w = 8'h4D;
    int n0 = acc_n;
    ready_i = 1'b1;
    for (int i = 0; i < W - 1; i++) send_slot(w[i] ? 1 : 0);
    cout = 1'b1;
    tick(S + 1);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=%b want=0", valid_o);
    end
    tick(1);
    checks++;
    if (valid_o !== 1'b1 || word_o !== w) begin
      failures++;
      $display("FAIL latency_word got=%b/%h want=1/%h", valid_o, word_o, w);
    end
    tick(1);
    checks++;
    if (valid_o !== 1'b0 || acc_n - n0 != 1) begin
      failures++;
      $display("FAIL latency_one_cycle got valid=%b accepted=%0d want=0/1", valid_o, acc_n - n0);
    end
    cout = 1'b0; tick(3);
  endtask

  task automatic test_overrun();
    int ov0 = ov_n;
    ready_i = 1'b0;
    send_word(8'hA5);
    checks++;
    if (valid_o !== 1'b1 || word_o !== 8'hA5) begin
      failures++;
      $display("FAIL overrun_first got=%b/%h want=1/a5", valid_o, word_o);
    end
    send_word(8'h3C);
    checks++;
    if (word_o !== 8'hA5 || valid_o !== 1'b1 || ov_n - ov0 != 1) begin
      failures++;
      $display("FAIL overrun_drop got=%h valid=%b ov=%0d want=a5/1/1", word_o, valid_o, ov_n - ov0);
    end
    ready_i = 1'b1;
    tick(1);
    checks++;
    if (valid_o !== 1'b0 || acc_w[acc_n-1] !== 8'hA5) begin
      failures++;
      $display("FAIL overrun_drain got valid=%b word=%h want=0/a5", valid_o, acc_w[acc_n-1]);
    end
  endtask

  task automatic test_viol();
    logic [W-1:0] w;
    int v0 = vi_n, n0 = acc_n;
    ready_i = 1'b1;
    w = W'($urandom) | 8'h01;
    send_slot(2);
    for (int i = 1; i < W; i++) send_slot(w[i] ? 1 : 0);
    checks++;
    if (vi_n - v0 != 1 || acc_n - n0 != 1 || acc_w[acc_n-1] !== w) begin
      failures++;
      $display("FAIL viol got viol=%0d n=%0d word=%h want=1/1/%h", vi_n - v0, acc_n - n0, acc_w[acc_n-1], w);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w;
    int t0 = to_n, n0 = acc_n;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send_slot(int'($urandom_range(0, 1)));
    tick(TO - 20);
    checks++;
    if (to_n - t0 != 0) begin
      failures++;
      $display("FAIL timeout_early got=%0d want=0", to_n - t0);
    end
    tick(40);
    checks++;
    if (to_n - t0 != 1 || acc_n - n0 != 0) begin
      failures++;
      $display("FAIL timeout_fire got tmo=%0d words=%0d want=1/0", to_n - t0, acc_n - n0);
    end
    w = W'($urandom);
    send_word(w);
    checks++;
    if (acc_n - n0 != 1 || acc_w[acc_n-1] !== w || to_n - t0 != 1) begin
      failures++;
      $display("FAIL timeout_recover got n=%0d word=%h want=1/%h", acc_n - n0, acc_w[acc_n-1], w);
    end
  endtask

  task automatic test_midword_reset();
    int n0, t0;
    ready_i = 1'b0;
    send_word(W'($urandom));
    for (int i = 0; i < 5; i++) send_slot(int'($urandom_range(0, 1)));
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({word_o, valid_o, overrun_o, viol_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=0", {word_o, valid_o, overrun_o, viol_o, timeout_o});
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n0 = acc_n; t0 = to_n;
    ready_i = 1'b1;
    send_word(8'hFF);
    checks++;
    if (acc_n - n0 != 1 || acc_w[acc_n-1] !== 8'hFF || to_n - t0 != 0) begin
      failures++;
      $display("FAIL midreset_word got n=%0d word=%h tmo=%0d want=1/ff/0", acc_n - n0, acc_w[acc_n-1], to_n - t0);
    end
  endtask

  // Consumer accepts the held word in the very cycle the next one completes.
  task automatic test_back_to_back();
    logic [W-1:0] w1, w2;
    int ov0 = ov_n;
    w1 = W'($urandom); w2 = W'($urandom);
    ready_i = 1'b0;
    send_word(w1);
    for (int i = 0; i < W - 1; i++) send_slot(w2[i] ? 1 : 0);
    repeat (int'(w2[W-1])) pulse_dout();
    cout = 1'b1;
    tick(S + 1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || word_o !== w2 || ov_n - ov0 != 0) begin
      failures++;
      $display("FAIL b2b_load got=%b/%h ov=%0d want=1/%h/0", valid_o, word_o, ov_n - ov0, w2);
    end
    checks++;
    if (acc_w[acc_n-1] !== w1) begin
      failures++;
      $display("FAIL b2b_accept got=%h want=%h", acc_w[acc_n-1], w1);
    end
    cout = 1'b0; tick(3);
    ready_i = 1'b1; tick(1);
  endtask

  // Random words; some "1" slots get a duplicate dout pulse.
  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int n0 = acc_n, v0 = vi_n, dup = 0;
      logic [W-1:0] exp_w = '0;
      ready_i = 1'b1;
      for (int i = 0; i < W; i++) begin
        int np = int'($urandom_range(0, 2));
        if (np > 0) exp_w = exp_w + W'(1 << i);
        if (np > 1) dup++;
        send_slot(np);
      end
      checks++;
      if (acc_n - n0 != 1 || acc_w[acc_n-1] !== exp_w || vi_n - v0 != dup) begin
        failures++;
        $display("FAIL random_%0d got n=%0d word=%h viol=%0d want=1/%h/%0d",
                 k, acc_n - n0, acc_w[acc_n-1], vi_n - v0, exp_w, dup);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overrun();
    test_viol();
    test_timeout();
    test_midword_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctf_pulse_rx.md
CTF_PULSE_RX -- requirements
Module: ctf_pulse_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of bit slots per received word.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flip-flops in each input synchronizer (minimum 2).
REQ-003 The block SHALL have parameter TIMEOUT, default 255: idle clk cycles allowed between cout pulses inside a partial word.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port dout  input  1  asynchronous data pulse from the last counterflow cell; a pulse marks a "1" in the current slot.
REQ-007 The block SHALL have port cout  input  1  asynchronous clock pulse from the last cell; each pulse closes one bit slot.
REQ-008 The block SHALL have port word_o  output  WIDTH  assembled word; the first-received bit is in bit 0.
REQ-009 The block SHALL have port valid_o  output  1  word_o holds an unconsumed word.
REQ-010 The block SHALL have port ready_i  input  1  consumer accepts word_o when valid_o && ready_i.
REQ-011 The block SHALL have port overrun_o  output  1  one-cycle pulse when a word completes while it cannot be stored.
REQ-012 The block SHALL have port viol_o  output  1  one-cycle pulse when a slot receives more than one dout pulse.
REQ-013 The block SHALL have port timeout_o  output  1  one-cycle pulse when a partial word is discarded.

Function
REQ-014 Input pulses SHALL be at least 2 clk periods high and 2 low; shorter pulses are outside the contract and SHALL NOT be checked.
REQ-015 Each of dout and cout SHALL pass through a SYNC_STAGES synchronizer followed by a rising-edge detector, producing one-cycle dout_e and cout_e.
REQ-016 A slot SHALL be "1" if dout_e occurred since the previous cout_e, including the same cycle as the closing cout_e; otherwise "0".
REQ-017 A second dout_e in the same slot SHALL pulse viol_o in that cycle; the slot value stays 1.
REQ-018 The FSM SHALL have states IDLE (no bits collected) and COLLECT (1..WIDTH-1 bits collected).
REQ-019 IDLE -> COLLECT on cout_e when WIDTH>1; COLLECT stays while bit_cnt < WIDTH-1; on the WIDTH-th cout_e the word completes and the FSM returns to IDLE.
REQ-020 A dout_e in IDLE SHALL open a slot without a state change.
REQ-021 On completion, if valid_o==0 or ready_i==1 in that cycle, word_o SHALL load the new word and valid_o SHALL be 1 on the next cycle, SYNC_STAGES+2 clk after the raw cout rising edge.
REQ-022 On completion with valid_o==1 and ready_i==0, the new word SHALL be dropped, word_o kept, and overrun_o pulsed.
REQ-023 On acceptance without a simultaneous completion, valid_o SHALL clear on the next cycle.
REQ-024 In COLLECT, an idle counter SHALL count cycles without cout_e; when it reaches TIMEOUT, the partial word and the open-slot flag SHALL be discarded, timeout_o pulsed, and the FSM SHALL return to IDLE.
REQ-025 The idle counter SHALL reset on every cout_e and SHALL saturate; it is ceil(log2(TIMEOUT+1)) bits wide.
REQ-026 bit_cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL clear on completion and on timeout.

Reset
REQ-027 rst_n low SHALL immediately force the following: state=IDLE, bit_cnt=0, idle counter=0, slot flag=0, all synchronizer flops=0, word_o=0, valid_o=0, overrun_o=0, viol_o=0, timeout_o=0.
REQ-028 Reset mid-word SHALL discard the partial word without a timeout_o pulse; the first cout_e after release starts slot 0.

Structure
REQ-029 Package ctf_pkg SHALL hold the FSM state typedef and the default WIDTH and TIMEOUT constants.
REQ-030 One sub-module, ctf_pulse_sync (synchronizer plus rising-edge detector, parameter SYNC_STAGES), SHALL be instantiated once for dout and once for cout.

Verification
REQ-031 Reset, then for WIDTH=8 send slots 1,0,1,1,0,0,1,0 with ready_i=1 -> word_o=8'h4D and valid_o for one cycle, SYNC_STAGES+2 clk after the 8th cout edge.
REQ-032 With ready_i=0, send words 8'hA5 then 8'h3C -> word_o stays 8'hA5, overrun_o pulses once; raising ready_i clears valid_o.
REQ-033 Send two dout pulses and then one cout in slot 0 -> viol_o pulses once and bit 0=1.
REQ-034 Send 3 slots, then no cout for TIMEOUT cycles -> timeout_o pulses and the FSM returns to IDLE; the next 8 slots yield a clean word.
REQ-035 Assert rst_n low after 5 slots -> all outputs are 0 immediately; 8 new slots 8'hFF after release give word_o=8'hFF.
REQ-036 Set ready_i=1 in the same cycle that the next word completes while valid_o=1 -> the new word loads, valid_o stays 1, and there is no overrun_o.
